enc_player: RTL and testbench

//   Encoder-signal playback: the transmit-side counterpart of the encoder edge reader.

---
 rtl/enc_pkg.sv | 20 ++
 rtl/enc_player.sv | 127 ++++++++++++
 tb/tb_enc_player.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared types for the encoder playback and reader paths.
//   CNT_W_DEF    default timestamp width
//   play_state_t playback FSM state
//   enc_event_t  one {timestamp, level, last} event as carried on the stream
package enc_pkg;

  localparam int CNT_W_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } play_state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] tgt;
    logic                 lvl;
    logic                 last;
  } enc_event_t;

endpackage

// File: rtl/enc_player.sv
// Encoder-signal playback. Takes {timestamp, level, last} events from an
// AXI-Stream and drives enc_out to each level once the free-running system
// counter reaches that event's timestamp.
//
// Ports:
//   clk, aresetn       clock, asynchronous active-low reset
//   enable             1 = run; 0 = drop any held event and hold enc_out
//   counter_in         free-running timestamp counter
//   s_axis_*           event stream: tdata = fire time, tuser = level, tlast = end of sequence
//   enc_out            generated encoder level (registered)
//   busy               an event is held, waiting for its fire time
//   done               one-cycle pulse when an event carrying tlast fires
//   late_cnt           saturating count of events fired after their timestamp
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing held; ready for a new event while enabled
// WAIT  | one event held; fires once counter_buf reaches its timestamp
module enc_player
  import enc_pkg::*;
#(
  parameter int   CNT_W      = CNT_W_DEF,
  parameter logic INIT_LEVEL = 1'b0,
  parameter int   LATE_W     = 16
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic [CNT_W-1:0]  s_axis_tdata,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              enc_out,
  output logic              busy,
  output logic              done,
  output logic [LATE_W-1:0] late_cnt
);

  play_state_t      state;
  play_state_t      state_nxt;
  logic [CNT_W-1:0] counter_buf;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] diff;
  logic             lvl_q;
  logic             last_q;
  logic             armed;
  logic             due;
  logic             fire;
  logic             late;
  logic             accept;
  logic             tready_int;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // Modular difference: MSB clear means the counter is at or past the
    // target, which stays correct across counter wrap for gaps < 2^(CNT_W-1).
    diff       = counter_buf - tgt_q;
    due        = ~diff[CNT_W-1];
    fire       = 1'b0;
    tready_int = 1'b0;
    state_nxt  = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // armed keeps tready low through reset and the first cycle after it
          tready_int = armed;
          if (armed && s_axis_tvalid) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (due) begin
            fire       = 1'b1;
            tready_int = 1'b1;
            state_nxt  = s_axis_tvalid ? WAIT : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    late   = fire && (diff != '0);
    accept = tready_int && s_axis_tvalid;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      counter_buf <= '0;
      tgt_q       <= '0;
      lvl_q       <= 1'b0;
      last_q      <= 1'b0;
      armed       <= 1'b0;
      enc_out     <= INIT_LEVEL;
      done        <= 1'b0;
      late_cnt    <= '0;
    end else begin
      counter_buf <= counter_in;
      armed       <= 1'b1;
      done        <= fire && last_q;
      if (accept) begin
        tgt_q  <= s_axis_tdata;
        lvl_q  <= s_axis_tuser;
        last_q <= s_axis_tlast;
      end
      if (fire) begin
        enc_out <= lvl_q;
      end
      if (late && (late_cnt != {LATE_W{1'b1}})) begin
        late_cnt <= late_cnt + LATE_W'(1);
      end
    end
  end

  assign s_axis_tready = tready_int;
  assign busy          = (state == WAIT);

endmodule

// File: tb/tb_enc_player.sv
module tb_enc_player;

  localparam int   CNT_W      = 64;
  localparam int   LATE_W     = 8;
  localparam logic INIT_LEVEL = 1'b0;
  localparam int   LATE_MAX   = (1 << LATE_W) - 1;
  localparam int   SAT_TOTAL  = (1 << LATE_W) + 3;

  logic              clk = 1'b0;
  logic              aresetn = 1'b1;
  logic              enable;
  logic [CNT_W-1:0]  counter_in;
  logic [CNT_W-1:0]  tdata;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  logic              enc_out;
  logic              busy;
  logic              done;
  logic [LATE_W-1:0] late_cnt;

  enc_player #(
    .CNT_W      (CNT_W),
    .INIT_LEVEL (INIT_LEVEL),
    .LATE_W     (LATE_W)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .enable        (enable),
    .counter_in    (counter_in),
    .s_axis_tdata  (tdata),
    .s_axis_tuser  (tuser),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .enc_out       (enc_out),
    .busy          (busy),
    .done          (done),
    .late_cnt      (late_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] cnt;
    logic [63:0] tgt;
    logic        lvl;
    int          exp_cyc;
    int          exp_late;
  } vec_t;

  vec_t vecs[7];

  logic        hs, rdy, got, seen, lvl_before, mid_done;
  logic        done_at_rise;
  logic [63:0] rise_at;
  int          late_at_rise, late0, cycles, n_acc, n_fired;
  logic        enc_at[256];
  logic        rdy_at[256];
  logic        done_at[256];

  // reference model state (event-level view of the player)
  logic        m_held, m_lvl, m_last, m_enc, m_done, m_armed, pend, m_due, exp_rdy;
  logic [63:0] m_tgt, m_cbuf;
  int          m_late;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Samples tready/handshake mid-cycle, then advances past the next edge.
  task automatic step(output logic hs_o, output logic rdy_o);
    #3;
    rdy_o = tready;
    hs_o  = tready && tvalid;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    aresetn = 1'b0;
    enable  = 1'b0;
    tvalid  = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    enable  = 1'b1;
  endtask

  initial begin
    vecs[0] = '{64'd500,  64'd300, 1'b1, 1,  1};
    vecs[1] = '{64'd100,  64'd100, 1'b0, 1,  0};
    vecs[2] = '{64'd90,   64'd100, 1'b1, 11, 0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'd2, 1'b0, 7, 0};
    vecs[4] = '{64'd1000, 64'd999, 1'b0, 1,  1};
    vecs[5] = '{64'd5,    64'd6,   1'b1, 2,  0};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0003, 1'b0, 5, 0};

    enable = 1'b1; counter_in = '0; tdata = '0; tuser = 1'b0; tlast = 1'b0; tvalid = 1'b0;
    #1 aresetn = 1'b0;
    tick();
    tick();
    chk("rst_enc_out", enc_out, INIT_LEVEL);
    chk("rst_tready", tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_late_cnt", late_cnt, 0);
    aresetn = 1'b1;

    // single event from a counter ramp starting at 0
    tvalid = 1'b1; tdata = 64'd100; tuser = 1'b1; tlast = 1'b1;
    rise_at = '0; done_at_rise = 1'b0; late_at_rise = -1;
    for (int i = 0; i < 150; i++) begin
      step(hs, rdy);
      if (hs) tvalid = 1'b0;
      counter_in = counter_in + 1;
      if (enc_out && rise_at == 0) begin
        rise_at = counter_in; done_at_rise = done; late_at_rise = int'(late_cnt);
      end
    end
    chk("t1_rise_count", rise_at, 102);
    chk("t1_done_at_rise", done_at_rise, 1);
    chk("t1_late_cnt", late_at_rise, 0);
    chk("t1_done_cleared", done, 0);

    // back-to-back: 160/0 then 200/1, 201/0, 202/1(last) held valid
    n_acc = 0;
    tvalid = 1'b1; tdata = 64'd160; tuser = 1'b0; tlast = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(hs, rdy);
      if (hs) begin
        n_acc++;
        case (n_acc)
          1: begin tdata = 64'd200; tuser = 1'b1; tlast = 1'b0; end
          2: begin tdata = 64'd201; tuser = 1'b0; tlast = 1'b0; end
          3: begin tdata = 64'd202; tuser = 1'b1; tlast = 1'b1; end
          default: tvalid = 1'b0;
        endcase
      end
      counter_in = counter_in + 1;
      enc_at[counter_in[7:0]]  = enc_out;
      rdy_at[counter_in[7:0]]  = rdy;
      done_at[counter_in[7:0]] = done;
    end
    chk("t2_rdy_160_fire", rdy_at[162], 1);
    chk("t2_enc_201", enc_at[201], 0);
    chk("t2_rdy_201", rdy_at[201], 0);
    chk("t2_enc_202", enc_at[202], 1);
    chk("t2_enc_203", enc_at[203], 0);
    chk("t2_enc_204", enc_at[204], 1);
    chk("t2_rdy_202", rdy_at[202], 1);
    chk("t2_rdy_203", rdy_at[203], 1);
    chk("t2_rdy_204", rdy_at[204], 1);
    chk("t2_done_203", done_at[203], 0);
    chk("t2_done_204", done_at[204], 1);
    chk("t2_done_205", done_at[205], 0);

    // late events: counter parked at 500, tgt=300, held valid until saturation
    tvalid = 1'b0; counter_in = 64'd500;
    tick(); tick();
    tvalid = 1'b1; tdata = 64'd300; tuser = 1'b0; tlast = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step(hs, rdy);
      if (hs) got = 1'b1;
    end
    chk("t3_accept", got, 1);
    n_acc = 1;
    step(hs, rdy);
    if (hs) n_acc++;
    chk("t3_enc_after_late", enc_out, 0);
    chk("t3_late_first", late_cnt, 1);
    n_fired = 1;
    mid_done = 1'b0;
    for (int i = 0; i < 600 && n_fired < SAT_TOTAL; i++) begin
      if (n_acc == SAT_TOTAL) tvalid = 1'b0;
      step(hs, rdy);
      if (hs) n_acc++;
      if (done) n_fired++;
      if (n_fired == LATE_MAX - 1 && !mid_done) begin
        chk("t3_late_below_max", late_cnt, LATE_MAX - 1);
        mid_done = 1'b1;
      end
    end
    tvalid = 1'b0;
    tick();
    chk("t3_fired_total", n_fired, SAT_TOTAL);
    chk("t3_late_saturated", late_cnt, LATE_MAX);

    // table: single events, latency in clocks from acceptance to done
    do_reset();
    for (int v = 0; v < 7; v++) begin
      tvalid = 1'b0; counter_in = vecs[v].cnt;
      tick(); tick();
      tvalid = 1'b1; tdata = vecs[v].tgt; tuser = vecs[v].lvl; tlast = 1'b1;
      late0 = int'(late_cnt);
      step(hs, rdy);
      chk($sformatf("vec%0d_tready", v), rdy, 1);
      tvalid = 1'b0;
      cycles = 0; got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        counter_in = counter_in + 1;
        step(hs, rdy);
        cycles++;
        if (done) got = 1'b1;
      end
      chk($sformatf("vec%0d_latency", v), cycles, vecs[v].exp_cyc);
      chk($sformatf("vec%0d_level", v), enc_out, vecs[v].lvl);
      chk($sformatf("vec%0d_late", v), int'(late_cnt) - late0, vecs[v].exp_late);
    end

    // abort: tgt=1000 held, enable dropped at counter 900
    counter_in = 64'd890; tick();
    lvl_before = enc_out;
    tvalid = 1'b1; tdata = 64'd1000; tuser = ~lvl_before; tlast = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step(hs, rdy);
      counter_in = counter_in + 1;
      if (hs) begin got = 1'b1; tvalid = 1'b0; end
    end
    chk("t5_accept", got, 1);
    for (int i = 0; i < 20 && counter_in != 900; i++) begin
      step(hs, rdy);
      counter_in = counter_in + 1;
    end
    chk("t5_busy_before", busy, 1);
    enable = 1'b0;
    step(hs, rdy);
    counter_in = counter_in + 1;
    chk("t5_busy_dropped", busy, 0);
    step(hs, rdy);
    chk("t5_tready_off", rdy, 0);
    seen = 1'b0;
    for (int i = 0; i < 120 && counter_in < 1010; i++) begin
      counter_in = counter_in + 1;
      step(hs, rdy);
      if (done || enc_out != lvl_before) seen = 1'b1;
    end
    chk("t5_no_fire_after_abort", seen, 0);
    enable = 1'b1;
    tvalid = 1'b1; tdata = 64'd1015; tuser = ~lvl_before; tlast = 1'b1;
    rise_at = '0;
    for (int i = 0; i < 15; i++) begin
      step(hs, rdy);
      if (hs) tvalid = 1'b0;
      counter_in = counter_in + 1;
      if (enc_out != lvl_before && rise_at == 0) rise_at = counter_in;
    end
    chk("t5_reenable_fire", rise_at, 1017);

    // async reset in the middle of WAIT
    counter_in = 64'd2000;
    tvalid = 1'b1; tdata = 64'd1990; tuser = 1'b1; tlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(hs, rdy);
      counter_in = counter_in + 1;
      if (hs) tvalid = 1'b0;
    end
    chk("t6_pre_level", enc_out, 1);
    tvalid = 1'b1; tdata = 64'd2050; tuser = 1'b0; tlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(hs, rdy);
      counter_in = counter_in + 1;
      if (hs) tvalid = 1'b0;
    end
    chk("t6_busy_held", busy, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_rst_enc_out", enc_out, INIT_LEVEL);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_late", late_cnt, 0);
    chk("t6_rst_tready", tready, 0);
    @(posedge clk);
    #1 aresetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      counter_in = counter_in + 1;
      step(hs, rdy);
      if (enc_out != INIT_LEVEL || done || busy) seen = 1'b1;
    end
    chk("t6_no_fire_after_reset", seen, 0);

    // randomized run against the reference model, crossing counter wrap
    do_reset();
    counter_in = 64'hFFFF_FFFF_FFFF_FC00;
    m_held = 1'b0; m_lvl = 1'b0; m_last = 1'b0; m_enc = INIT_LEVEL; m_done = 1'b0;
    m_armed = 1'b0; m_tgt = '0; m_cbuf = '0; m_late = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_enc_out", enc_out, m_enc);
      chk("rnd_busy", busy, m_held);
      chk("rnd_done", done, m_done);
      chk("rnd_late_cnt", late_cnt, m_late);
      counter_in = counter_in + 1;
      enable = ($urandom_range(99) < 97);
      if (!pend) begin
        tvalid = ($urandom_range(99) < 60);
        tdata  = counter_in + 64'($urandom_range(50)) - 64'd20;
        tuser  = 1'($urandom_range(1));
        tlast  = 1'($urandom_range(1));
      end
      #3;
      m_due   = m_held && (longint'(m_cbuf - m_tgt) >= 0);
      exp_rdy = enable && m_armed && (!m_held || m_due);
      chk("rnd_tready", tready, exp_rdy);
      hs   = exp_rdy && tvalid;
      pend = tvalid && !hs;
      @(posedge clk);
      m_done = 1'b0;
      if (!enable) begin
        m_held = 1'b0;
      end else begin
        if (m_due) begin
          m_enc  = m_lvl;
          m_done = m_last;
          if (m_cbuf != m_tgt && m_late < LATE_MAX) m_late++;
          m_held = 1'b0;
        end
        if (hs) begin
          m_held = 1'b1; m_tgt = tdata; m_lvl = tuser; m_last = tlast;
        end
      end
      m_cbuf  = counter_in;
      m_armed = 1'b1;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
